button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event.sv | 157 +++++++++++++++
 tb/tb_button_event.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
//
// Turns the press/release pulses of an upstream debouncer into gesture
// events: a single short click, a double click, or a long press. A long
// press also produces a level that stays high while the button is held.
//
// Parameters
//   LONG_T   : press duration, in clk cycles, that counts as a long press
//   DCLICK_T : window after a release, in clk cycles, for a second press
//   CW       : width of the internal state timer
//
// Ports
//   clk      : single clock; all state changes on its rising edge
//   rst_n    : synchronous active-low reset
//   st_i     : debounced button level
//   up_i     : one-cycle pulse marking a debounced press
//   dn_i     : one-cycle pulse marking a debounced release
//   click_o  : one-cycle pulse for a single short click
//   dclick_o : one-cycle pulse for a double click
//   long_o   : one-cycle pulse when a press reaches LONG_T
//   hold_o   : level, high while a long press is held
// ---------------------------------------------------------------------------
module button_event #(
    parameter logic [15:0] LONG_T   = 16'd50000,
    parameter logic [15:0] DCLICK_T = 16'd20000,
    parameter int          CW       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic st_i,
    input  logic up_i,
    input  logic dn_i,
    output logic click_o,
    output logic dclick_o,
    output logic long_o,
    output logic hold_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    // Last timer values before a timeout fires. The timer reads 0 in the
    // cycle a state is entered, so the threshold is N-1.
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_T - 16'd1);
    localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_T - 16'd1);

    state_t          state_q, state_d;
    logic [CW-1:0]   timer_q, timer_d;
    logic            click_q, click_d;
    logic            dclick_q, dclick_d;
    logic            long_q, long_d;
    logic            hold_q, hold_d;

    // A press and a release in the same cycle are contradictory; treat them
    // as neither having happened.
    logic up_v;
    logic dn_v;
    assign up_v = up_i & ~dn_i;
    assign dn_v = dn_i & ~up_i;

    // Next-state and pulse decode. Within each state the pulse-driven exit
    // is tested before the timeout, so a release beats a long press and a
    // second press beats a click timeout.
    always_comb begin
        state_d  = state_q;
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (up_v) begin
                    state_d = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (dn_v) begin
                    state_d = S_WAIT2;
                end else if (timer_q == LONG_LAST) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                end
            end
            S_WAIT2: begin
                if (up_v) begin
                    state_d = S_PRESS2;
                end else if (timer_q == DCLICK_LAST) begin
                    state_d = S_IDLE;
                    click_d = 1'b1;
                end
            end
            S_PRESS2: begin
                if (dn_v) begin
                    state_d  = S_IDLE;
                    dclick_d = 1'b1;
                end else if (timer_q == LONG_LAST) begin
                    // A second press that is held long enough becomes a long
                    // press; the pending double click is dropped.
                    state_d = S_LONG;
                    long_d  = 1'b1;
                end
            end
            S_LONG: begin
                // Losing the level also ends the hold, in case the release
                // pulse was missed.
                if (dn_v || !st_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timer restarts on every state change and saturates instead of
        // wrapping, so a long stay in any state cannot alias a threshold.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == {CW{1'b1}}) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        hold_d = (state_d == S_LONG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            click_q  <= 1'b0;
            dclick_q <= 1'b0;
            long_q   <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            click_q  <= click_d;
            dclick_q <= dclick_d;
            long_q   <= long_d;
            hold_q   <= hold_d;
        end
    end

    assign click_o  = click_q;
    assign dclick_o = dclick_q;
    assign long_o   = long_q;
    assign hold_o   = hold_q;

endmodule

// File: tb/tb_button_event.sv
// ---------------------------------------------------------------------------
// tb_button_event
//
// Bench for button_event with LONG_T=8, DCLICK_T=5. Each clock cycle is one
// vector. A timestamp-based gesture model predicts the four outputs after
// every edge; directed scenarios additionally check the cycle at which each
// event is reported, counted from the first vector of the scenario. An output
// "at cycle N" is the value visible just before edge N of the scenario.
// ---------------------------------------------------------------------------
module tb_button_event;

    localparam int LT = 8;
    localparam int DT = 5;

    logic clk = 1'b0;
    logic rst_n, st_i, up_i, dn_i;
    logic click_o, dclick_o, long_o, hold_o;

    button_event #(
        .LONG_T   (16'd8),
        .DCLICK_T (16'd5),
        .CW       (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_i     (st_i),
        .up_i     (up_i),
        .dn_i     (dn_i),
        .click_o  (click_o),
        .dclick_o (dclick_o),
        .long_o   (long_o),
        .hold_o   (hold_o)
    );

    always #5 clk = ~clk;

    // Gesture phases of the reference model.
    localparam int G_IDLE  = 0;  // nothing in progress
    localparam int G_DOWN1 = 1;  // first press held, started at m_t0
    localparam int G_GAP   = 2;  // released, waiting for a second press
    localparam int G_DOWN2 = 3;  // second press held
    localparam int G_HELD  = 4;  // long press reached, still held

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   m_phase = G_IDLE;
    int   m_t0 = 0;
    logic e_click = 1'b0, e_dclick = 1'b0, e_long = 1'b0, e_hold = 1'b0;

    // Per-scenario event log.
    int rel;
    int n_click, n_dclick, n_long;
    int click_at, dclick_at, long_at, hold_first, hold_last;

    // Reference: each phase remembers the edge at which it began; a timeout
    // fires on the edge that is exactly N cycles after that.
    task automatic model_edge(input logic r, input logic s, input logic u, input logic d);
        int   el;
        int   nxt;
        logic pu, pd;
        e_click  = 1'b0;
        e_dclick = 1'b0;
        e_long   = 1'b0;
        if (!r) begin
            m_phase = G_IDLE;
            m_t0    = cyc;
            e_hold  = 1'b0;
        end else begin
            pu  = u && !d;
            pd  = d && !u;
            el  = cyc - m_t0;
            nxt = m_phase;
            if (m_phase == G_IDLE) begin
                if (pu) nxt = G_DOWN1;
            end else if (m_phase == G_DOWN1) begin
                if (pd) nxt = G_GAP;
                else if (el == LT) begin nxt = G_HELD; e_long = 1'b1; end
            end else if (m_phase == G_GAP) begin
                if (pu) nxt = G_DOWN2;
                else if (el == DT) begin nxt = G_IDLE; e_click = 1'b1; end
            end else if (m_phase == G_DOWN2) begin
                if (pd) begin nxt = G_IDLE; e_dclick = 1'b1; end
                else if (el == LT) begin nxt = G_HELD; e_long = 1'b1; end
            end else begin
                if (pd || !s) nxt = G_IDLE;
            end
            if (nxt != m_phase) m_t0 = cyc;
            m_phase = nxt;
            e_hold  = (m_phase == G_HELD);
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic begin_seq();
        rel = 0;
        n_click = 0; n_dclick = 0; n_long = 0;
        click_at = -1; dclick_at = -1; long_at = -1;
        hold_first = -1; hold_last = -1;
    endtask

    // One vector: drive, clock, predict, sample away from the edge, compare.
    task automatic step(input logic r, input logic s, input logic u, input logic d);
        rst_n = r; st_i = s; up_i = u; dn_i = d;
        @(posedge clk);
        model_edge(r, s, u, d);
        cyc++;
        #1;
        vectors++;
        assert (click_o === e_click) else begin
            miscompares++;
            $error("FAIL click_o cyc=%0d: got %b, expected %b", cyc, click_o, e_click);
        end
        assert (dclick_o === e_dclick) else begin
            miscompares++;
            $error("FAIL dclick_o cyc=%0d: got %b, expected %b", cyc, dclick_o, e_dclick);
        end
        assert (long_o === e_long) else begin
            miscompares++;
            $error("FAIL long_o cyc=%0d: got %b, expected %b", cyc, long_o, e_long);
        end
        assert (hold_o === e_hold) else begin
            miscompares++;
            $error("FAIL hold_o cyc=%0d: got %b, expected %b", cyc, hold_o, e_hold);
        end
        if (click_o === 1'b1)  begin n_click++;  click_at  = rel + 1; end
        if (dclick_o === 1'b1) begin n_dclick++; dclick_at = rel + 1; end
        if (long_o === 1'b1)   begin n_long++;   long_at   = rel + 1; end
        if (hold_o === 1'b1) begin
            if (hold_first < 0) hold_first = rel + 1;
            hold_last = rel + 1;
        end
        rel++;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic st_lvl;
        logic u, d, r;

        rst_n = 1'b0; st_i = 1'b0; up_i = 1'b0; dn_i = 1'b0;

        // Reset: all outputs low.
        begin_seq();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_outputs", {click_o, dclick_o, long_o, hold_o}, 0);
        idle_cycles(3);

        // Single click: up@0, dn@3 -> click at 9 only.
        begin_seq();
        for (int k = 0; k < 16; k++) step(1'b1, k < 3, k == 0, k == 3);
        chk("single_click_at", click_at, 9);
        chk("single_click_n", n_click, 1);
        chk("single_other_n", n_dclick + n_long, 0);
        idle_cycles(3);

        // Double click: up@0, dn@3, up@6, dn@8 -> dclick at 9, no click.
        begin_seq();
        for (int k = 0; k < 18; k++)
            step(1'b1, (k < 3) || (k >= 6 && k < 8), k == 0 || k == 6, k == 3 || k == 8);
        chk("double_dclick_at", dclick_at, 9);
        chk("double_dclick_n", n_dclick, 1);
        chk("double_click_n", n_click, 0);
        idle_cycles(3);

        // Long press: up@0, held, dn@20 -> long at 9, hold 9..20.
        begin_seq();
        for (int k = 0; k < 28; k++) step(1'b1, k < 20, k == 0, k == 20);
        chk("long_at", long_at, 9);
        chk("long_n", n_long, 1);
        chk("long_hold_first", hold_first, 9);
        chk("long_hold_last", hold_last, 20);
        chk("long_other_n", n_click + n_dclick, 0);
        idle_cycles(3);

        // Release on the long threshold edge: release wins, click follows.
        begin_seq();
        for (int k = 0; k < 20; k++) step(1'b1, k < 8, k == 0, k == 8);
        chk("bnd_release_long_n", n_long, 0);
        chk("bnd_release_click_at", click_at, 14);
        idle_cycles(3);

        // Release one cycle earlier: also a plain click.
        begin_seq();
        for (int k = 0; k < 20; k++) step(1'b1, k < 7, k == 0, k == 7);
        chk("bnd_early_long_n", n_long, 0);
        chk("bnd_early_click_at", click_at, 13);
        idle_cycles(3);

        // Second press on the click timeout edge: press wins.
        begin_seq();
        for (int k = 0; k < 20; k++)
            step(1'b1, (k < 3) || (k >= 8 && k < 10), k == 0 || k == 8, k == 3 || k == 10);
        chk("bnd_press_click_n", n_click, 0);
        chk("bnd_press_dclick_at", dclick_at, 11);
        idle_cycles(3);

        // Reset for one cycle during the gap: sequence abandoned.
        begin_seq();
        for (int k = 0; k < 20; k++) step(k != 5, k < 3, k == 0, k == 3);
        chk("rst_gap_click_n", n_click, 0);
        chk("rst_gap_any_n", n_dclick + n_long + (hold_first >= 0 ? 1 : 0), 0);
        idle_cycles(3);

        // Reset while a long press is held; still held afterwards but no
        // new press pulse, so nothing may be reported.
        begin_seq();
        for (int k = 0; k < 30; k++) step(k != 12, k < 25, k == 0, k == 25);
        chk("rst_held_long_n", n_long, 1);
        chk("rst_held_hold_last", hold_last, 12);
        idle_cycles(3);

        // Simultaneous up and dn in idle: ignored.
        begin_seq();
        for (int k = 0; k < 14; k++) step(1'b1, 1'b0, k == 0, k == 0);
        chk("updn_idle_any_n", n_click + n_dclick + n_long + (hold_first >= 0 ? 1 : 0), 0);
        idle_cycles(3);

        // Random gestures against the model.
        st_lvl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            u = 1'b0; d = 1'b0; r = 1'b1;
            if ($urandom_range(0, 199) == 0) r = 1'b0;
            if ($urandom_range(0, 49) == 0) begin
                u = 1'b1; d = 1'b1;
            end else if (!st_lvl && $urandom_range(0, 99) < 18) begin
                u = 1'b1; st_lvl = 1'b1;
            end else if (st_lvl && $urandom_range(0, 99) < 12) begin
                d = 1'b1; st_lvl = 1'b0;
            end else if (st_lvl && $urandom_range(0, 99) == 0) begin
                st_lvl = 1'b0;
            end
            step(r, st_lvl, u, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
